// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, MEM-stage redirects,
// multi-cycle data-memory waits with a timeout watchdog. Optional counters: PIPE_CTRL_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             mem_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             perf_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       state,
    output logic             dmem_timeout,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;
    logic              lu;
    logic              miss;
    logic              advance;

    assign lu = ex_memread && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign miss = dmem_req && !dmem_ack;

    // The pipeline may move only when no data-memory access is outstanding.
    assign advance = !arst &&
                     (((state_q == ST_RUN) && !miss) || ((state_q == ST_WAIT) && dmem_ack));

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (advance) begin
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (mem_redirect) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (lu) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= ST_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (miss) begin
                        state_q  <= ST_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        state_q  <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                        state_q   <= ST_ERR;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q  <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign dmem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (perf_clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (state_q != ST_ERR) && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + CNT_W'(1);
            if (ex_mem_flush && (flush_q != {CNT_W{1'b1}}))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign perf_stall_cnt  = '0;
    assign perf_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a cycle-level reference model and literal spot checks.
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int WAIT_W   = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef PIPE_CTRL_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic             clk = 1'b0;
    logic             arst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_memread;
    logic             mem_redirect, dmem_req, dmem_ack, perf_clr;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]       state;
    logic             dmem_timeout;
    logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;

    int checks = 0;
    int errors = 0;

    // model: mode 0 run, 1 waiting on memory, 2 error
    int m_mode  = 0;
    int m_wait  = 0;
    int m_to    = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .arst(arst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_redirect(mem_redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .perf_clr(perf_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .state(state), .dmem_timeout(dmem_timeout),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected {pc,if_id,id_ex,ex_mem,mem_wb en; if_id,id_ex,ex_mem flush}
    function automatic logic [7:0] exp_ctrl();
        bit hit_rs1, hit_rs2, lu, miss, moving;
        hit_rs1 = id_uses_rs1 && (id_rs1 == ex_rd);
        hit_rs2 = id_uses_rs2 && (id_rs2 == ex_rd);
        lu      = ex_memread && (ex_rd != 0) && (hit_rs1 || hit_rs2);
        miss    = dmem_req && !dmem_ack;
        moving  = (m_mode == 0 && !miss) || (m_mode == 1 && dmem_ack);
        if (arst || !moving) return 8'b00000_000;
        if (mem_redirect)     return 8'b11111_111;
        if (lu)               return 8'b00111_010;
        return 8'b11111_000;
    endfunction

    always @(posedge clk or posedge arst) begin
        logic [7:0] e;
        if (arst) begin
            m_mode = 0; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
        end else begin
            e = exp_ctrl();
            if (PERF_ON != 0) begin
                if (perf_clr) begin
                    m_stall = 0; m_flush = 0;
                end else begin
                    if (!e[7] && m_mode != 2 && m_stall < CNT_MAX) m_stall++;
                    if (e[0] && m_flush < CNT_MAX) m_flush++;
                end
            end
            if (m_mode == 0) begin
                if (dmem_req && !dmem_ack) begin m_mode = 1; m_wait = 1; end
            end else if (m_mode == 1) begin
                if (dmem_ack) begin m_mode = 0; m_wait = 0; end
                else if (m_wait == MAX_WAIT) begin m_mode = 2; m_to = 1; end
                else m_wait++;
            end
        end
    end

    always @(negedge clk) begin
        chk("ctrl", int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                          if_id_flush, id_ex_flush, ex_mem_flush}), int'(exp_ctrl()));
        chk("state", int'(state), m_mode);
        chk("timeout", int'(dmem_timeout), m_to);
        chk("stall_cnt", int'(perf_stall_cnt), m_stall);
        chk("flush_cnt", int'(perf_flush_cnt), m_flush);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic mr,
                          input logic redir, input logic req, input logic ack, input logic clr);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_memread = mr; mem_redirect = redir;
        dmem_req = req; dmem_ack = ack; perf_clr = clr;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        arst = 1'b1;
        idle();
        cyc(); cyc();
        arst = 1'b0;
        #1;
        chk("lit_idle_pc_en", int'(pc_en), 1);
        cyc();

        // reset mid-wait with every input high
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("lit_wait_state", int'(state), 1);
        set_in(5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #2 arst = 1'b1;
        #1;
        chk("lit_rst_en", int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 0);
        chk("lit_rst_flush", int'({if_id_flush, id_ex_flush, ex_mem_flush}), 0);
        chk("lit_rst_state", int'(state), 0);
        chk("lit_rst_timeout", int'(dmem_timeout), 0);
        cyc();
        arst = 1'b0;
        #1;
        chk("lit_release_en", int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 31);
        cyc();

        // load-use on rs2, then the non-hazard variants
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lit_lu_pc_en", int'(pc_en), 0);
        chk("lit_lu_idex_flush", int'(id_ex_flush), 1);
        cyc();
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lit_lu_rd0_pc_en", int'(pc_en), 1);
        cyc();
        set_in(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        set_in(5'd9, 5'd1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        set_in(5'd9, 5'd1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();

        // redirect beats load-use; redirect under a miss waits for the ack
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lit_redir_lu", int'({pc_en, if_id_flush, id_ex_flush, ex_mem_flush}), 15);
        cyc();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(); cyc();
        dmem_ack = 1'b1;
        #1;
        chk("lit_redir_ack_flush", int'(ex_mem_flush), 1);
        cyc();
        idle();
        cyc();

        // miss with ack on the 3rd wait cycle
        dmem_req = 1'b1;
        repeat (3) cyc();
        dmem_ack = 1'b1;
        cyc();
        idle();
        #1;
        chk("lit_ack3_state", int'(state), 0);
        cyc();

        // miss with ack on the final allowed wait cycle; four stalled cycles
        perf_clr = 1'b1;
        cyc();
        perf_clr = 1'b0;
        dmem_req = 1'b1;
        repeat (4) cyc();
        dmem_ack = 1'b1;
        #1;
        chk("lit_ack_at_max_pc_en", int'(pc_en), 1);
        cyc();
        idle();
        #1;
        chk("lit_ack_at_max_state", int'(state), 0);
        chk("lit_stall_cnt4", int'(perf_stall_cnt), 4 * PERF_ON);
        cyc();

        // timeout, then a late ack is ignored
        dmem_req = 1'b1;
        repeat (5) cyc();
        chk("lit_err_state", int'(state), 2);
        chk("lit_err_timeout", int'(dmem_timeout), 1);
        dmem_ack = 1'b1;
        mem_redirect = 1'b1;
        #1;
        chk("lit_err_pc_en", int'(pc_en), 0);
        cyc(); cyc();
        chk("lit_err_hold", int'(state), 2);
        arst = 1'b1;
        #1;
        idle();
        cyc();
        arst = 1'b0;
        cyc();

        // flush counter saturation and clear priority
        perf_clr = 1'b1;
        cyc();
        perf_clr = 1'b0;
        mem_redirect = 1'b1;
        repeat (20) cyc();
        chk("lit_flush_sat", int'(perf_flush_cnt), 15 * PERF_ON);
        perf_clr = 1'b1;
        cyc();
        perf_clr = 1'b0;
        chk("lit_flush_clr", int'(perf_flush_cnt), 0);
        cyc();
        chk("lit_flush_after_clr", int'(perf_flush_cnt), PERF_ON);
        idle();
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
